// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator at the head of IF.
//   Holds the fetch PC and presents it to the I-cache through a valid/ready
//   handshake. Trap and branch redirects are applied by priority, and returns
//   are predicted from a circular return-address stack (RAS).
// Ports:
//   clk, rst           clock (rising edge); synchronous active-low reset
//   i_en               hazard-unit enable (0 stalls sequential advance)
//   i_fetch_ready      I-cache accepts the current pc
//   o_fetch_valid      pc is a valid fetch request
//   o_pc               current fetch address (registered)
//   o_redirect         pc was redirected on the previous edge (flush IF/ID)
//   i_trap_valid/vec   take trap to handler address
//   i_br_valid/target  EX branch redirect
//   i_ras_push/addr    decode saw a call; push return address
//   i_ras_pop          decode saw a return; predict from the RAS top
//   o_ras_count        number of valid RAS entries
module pc_gen #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic                         i_fetch_ready,
  output logic                         o_fetch_valid,
  output logic [XLEN-1:0]              o_pc,
  output logic                         o_redirect,
  input  logic                         i_trap_valid,
  input  logic [XLEN-1:0]              i_trap_vec,
  input  logic                         i_br_valid,
  input  logic [XLEN-1:0]              i_br_target,
  input  logic                         i_ras_push,
  input  logic [XLEN-1:0]              i_ras_push_addr,
  input  logic                         i_ras_pop,
  output logic [$clog2(RAS_DEPTH):0]   o_ras_count
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  // Redirect targets are forced onto an INC-aligned boundary.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC) - XLEN'(1));

  logic [XLEN-1:0] r_pc;
  logic            r_fetch_valid;
  logic            r_redirect;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];

  logic            w_advance;
  logic            w_stack_ok;
  logic            w_do_push;
  logic            w_do_pop;
  logic [XLEN-1:0] w_top;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_redir_nxt;
  logic            w_wr_en;
  logic [PW-1:0]   w_wr_idx;

  assign w_advance  = i_en & r_fetch_valid & i_fetch_ready;
  // RAS ops are only honoured on the path actually being fetched; anything
  // arriving with a redirect belongs to a squashed path.
  assign w_stack_ok = w_advance & ~i_trap_valid & ~i_br_valid;
  assign w_do_push  = w_stack_ok & i_ras_push;
  assign w_do_pop   = w_stack_ok & i_ras_pop & (r_count != '0);
  assign w_top      = r_ras[r_ptr];

  always_comb begin
    w_pc_nxt    = r_pc;
    w_redir_nxt = 1'b0;
    if (i_trap_valid) begin
      w_pc_nxt    = i_trap_vec & ALIGN_MASK;
      w_redir_nxt = 1'b1;
    end else if (i_br_valid) begin
      w_pc_nxt    = i_br_target & ALIGN_MASK;
      w_redir_nxt = 1'b1;
    end else if (w_do_pop) begin
      w_pc_nxt    = w_top;
    end else if (w_advance) begin
      w_pc_nxt    = r_pc + XLEN'(INC);
    end
  end

  // Push+pop together replaces the top in place; a lone push writes one
  // above the top, which on a full stack is the oldest entry.
  always_comb begin
    w_wr_en  = w_do_push;
    w_wr_idx = w_do_pop ? r_ptr : r_ptr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_VEC;
      r_fetch_valid <= 1'b0;
      r_redirect    <= 1'b0;
      r_ptr         <= '0;
      r_count       <= '0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_fetch_valid <= 1'b1;
      r_redirect    <= w_redir_nxt;
      if (i_trap_valid) begin
        r_count <= '0;
      end else if (w_do_push && !w_do_pop) begin
        r_ptr <= r_ptr + PW'(1);
        if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + CW'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_ptr   <= r_ptr - PW'(1);
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Stack storage carries no reset; r_count alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (rst && w_wr_en) r_ras[w_wr_idx] <= i_ras_push_addr;
  end

  assign o_pc          = r_pc;
  assign o_fetch_valid = r_fetch_valid;
  assign o_redirect    = r_redirect;
  assign o_ras_count   = r_count;
endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst, en, rdy, trap, br, push, pop;
  logic [31:0] tvec, btgt, paddr;
  logic        fv, redir;
  logic [31:0] pc;
  logic [2:0]  cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_fetch_ready(rdy),
    .o_fetch_valid(fv), .o_pc(pc), .o_redirect(redir),
    .i_trap_valid(trap), .i_trap_vec(tvec),
    .i_br_valid(br), .i_br_target(btgt),
    .i_ras_push(push), .i_ras_push_addr(paddr), .i_ras_pop(pop),
    .o_ras_count(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, en, rdy, trap, br, push, pop;
    logic [31:0] tvec, btgt, paddr;
    logic [31:0] epc;
    bit          efv, ered;
    int          ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit rd, bit t, logic [31:0] tv, bit b,
                              logic [31:0] bt, bit pu, logic [31:0] pa, bit po,
                              logic [31:0] epc, bit efv, bit ered, int ecnt);
    vec_t v;
    v.rst = r; v.en = e; v.rdy = rd; v.trap = t; v.tvec = tv; v.br = b; v.btgt = bt;
    v.push = pu; v.paddr = pa; v.pop = po;
    v.epc = epc; v.efv = efv; v.ered = ered; v.ecnt = ecnt;
    return v;
  endfunction

  // sequential (no redirect) row, out of reset
  function automatic vec_t sq(bit e, bit rd, bit pu, logic [31:0] pa, bit po,
                              logic [31:0] epc, int ecnt);
    return mk(1, e, rd, 0, 0, 0, 0, pu, pa, po, epc, 1, 0, ecnt);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; en = v.en; rdy = v.rdy; trap = v.trap; tvec = v.tvec;
    br = v.br; btgt = v.btgt; push = v.push; paddr = v.paddr; pop = v.pop;
  endtask

  task automatic step_check(vec_t v, int idx);
    drive(v);
    @(posedge clk);
    #1;
    chk("pc", idx, pc, v.epc);
    chk("fetch_valid", idx, 32'(fv), 32'(v.efv));
    chk("redirect", idx, 32'(redir), 32'(v.ered));
    chk("ras_count", idx, 32'(cnt), 32'(v.ecnt));
  endtask

  initial begin
    // T1 reset, then sequential fetch
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h0, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h4, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h8, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'hC, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h10, 0));
    // T2 stall: ready low then enable low
    for (int i = 0; i < 3; i++) tbl.push_back(sq(1, 0, 0, 0, 0, 32'h10, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(sq(0, 1, 0, 0, 0, 32'h10, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h14, 0));
    // T4 RAS: five pushes into depth 4, then five pops
    tbl.push_back(sq(1, 1, 1, 32'h20, 0, 32'h18, 1));
    tbl.push_back(sq(1, 1, 1, 32'h40, 0, 32'h1C, 2));
    tbl.push_back(sq(1, 1, 1, 32'h60, 0, 32'h20, 3));
    tbl.push_back(sq(1, 1, 1, 32'h80, 0, 32'h24, 4));
    tbl.push_back(sq(1, 1, 1, 32'hA0, 0, 32'h28, 4));
    tbl.push_back(sq(1, 1, 0, 0, 1, 32'hA0, 3));
    tbl.push_back(sq(1, 1, 0, 0, 1, 32'h80, 2));
    tbl.push_back(sq(1, 1, 0, 0, 1, 32'h60, 1));
    tbl.push_back(sq(1, 1, 0, 0, 1, 32'h40, 0));
    tbl.push_back(sq(1, 1, 0, 0, 1, 32'h44, 0));
    // push while not advancing is ignored
    tbl.push_back(sq(1, 0, 1, 32'h77, 0, 32'h44, 0));
    // push+pop together: pc takes top, top replaced, count unchanged
    tbl.push_back(sq(1, 1, 1, 32'h300, 0, 32'h48, 1));
    tbl.push_back(sq(1, 1, 1, 32'h400, 1, 32'h300, 1));
    tbl.push_back(sq(1, 1, 0, 0, 1, 32'h400, 0));
    tbl.push_back(sq(1, 1, 1, 32'h500, 0, 32'h404, 1));
    tbl.push_back(sq(1, 1, 1, 32'h600, 0, 32'h408, 2));
    // T6 branch squashes push, low bits cleared
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 32'h203, 1, 32'h999, 0, 32'h200, 1, 1, 2));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h204, 2));
    // branch redirect ignores stall
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 32'h300, 1, 1, 2));
    tbl.push_back(sq(0, 0, 0, 0, 0, 32'h300, 2));
    // T3 trap beats branch and pop, flushes RAS
    tbl.push_back(mk(1, 1, 1, 1, 32'h100, 1, 32'h80, 0, 0, 1, 32'h100, 1, 1, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h104, 0));
    // misaligned trap vector
    tbl.push_back(mk(1, 1, 1, 1, 32'h10F, 0, 0, 0, 0, 0, 32'h10C, 1, 1, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h110, 0));
    // T5 wrap
    tbl.push_back(mk(1, 1, 1, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 1, 1, 0));
    tbl.push_back(sq(1, 1, 0, 0, 0, 32'h0, 0));

    foreach (tbl[i]) step_check(tbl[i], i);

    // Reset arriving alongside a trap with live RAS entries
    step_check(sq(1, 1, 1, 32'h700, 0, 32'h4, 1), 100);
    step_check(mk(0, 1, 1, 1, 32'h100, 1, 32'h80, 0, 0, 0, 32'h0, 0, 0, 0), 101);
    step_check(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0), 102);
    step_check(sq(1, 1, 0, 0, 1, 32'h0, 0), 103);
    // pop right after reset finds an empty stack
    step_check(sq(1, 1, 0, 0, 1, 32'h4, 0), 104);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
